// File: rtl/sdpram_stream_fifo_pkg.sv
// sdpram_stream_fifo_pkg: shared types and sizing helpers for the RAM-backed stream FIFO.
package sdpram_stream_fifo_pkg;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdpram_stream_obuf.sv
// sdpram_stream_obuf: 2-entry output buffer absorbing the RAM read latency.
module sdpram_stream_obuf
    import sdpram_stream_fifo_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       buf_occ
);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             pop;

    always_comb begin
        pop     = state_q != BUF_EMPTY && m_ready;
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: if (load) begin
                head_d  = load_data;
                state_d = BUF_ONE;
            end
            BUF_ONE: if (load && pop) begin
                head_d = load_data;
            end else if (load) begin
                tail_d  = load_data;
                state_d = BUF_TWO;
            end else if (pop) begin
                state_d = BUF_EMPTY;
            end
            BUF_TWO: if (pop) begin
                head_d  = tail_q;
                state_d = BUF_ONE;
            end
            default: state_d = BUF_EMPTY;
        endcase
        m_valid = state_q != BUF_EMPTY;
        m_data  = head_q;
        buf_occ = state_q == BUF_TWO ? 2'd2 : state_q == BUF_ONE ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Read credit keeps a third word from ever arriving while both entries are full.
    assert property (@(posedge clk) disable iff (rst) !(load && state_q == BUF_TWO));

endmodule

// File: rtl/sdpram_stream_fifo.sv
// sdpram_stream_fifo: valid/ready FIFO whose storage is an external simple dual-port RAM
// with one-cycle read latency; a small output buffer keeps the downstream at full rate.
module sdpram_stream_fifo
    import sdpram_stream_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       S_VALID,
    output logic                       S_READY,
    input  logic [WIDTH-1:0]           S_DATA,
    output logic                       M_VALID,
    input  logic                       M_READY,
    output logic [WIDTH-1:0]           M_DATA,
    output logic                       RAM_WEN,
    output logic [$clog2(DEPTH)-1:0]   RAM_WADDR,
    output logic [WIDTH-1:0]           RAM_WDATA,
    output logic [WIDTH/8-1:0]         RAM_WSTRB,
    output logic                       RAM_REN,
    output logic [$clog2(DEPTH)-1:0]   RAM_RADDR,
    input  logic                       RAM_RVALID,
    input  logic [WIDTH-1:0]           RAM_RDATA,
    output logic [$clog2(DEPTH)+1:0]   COUNT,
    output logic                       FULL,
    output logic                       EMPTY
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = AW + 2;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, resident;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic          push, pop, ren, load;
    logic [1:0]    buf_occ;

    always_comb begin
        resident   = wptr_q - rptr_q;
        FULL       = resident == PW'(DEPTH);
        S_READY    = !FULL;
        push       = S_VALID && S_READY && !RST;
        pop        = M_VALID && M_READY;
        // Issue only when the word is guaranteed a buffer slot on its return.
        ren        = resident != '0 && ({1'b0, buf_occ} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
        load       = RAM_RVALID && inflight_q;
        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(ren);
        inflight_d = ren;
        count_d    = count_q + CW'(push) - CW'(pop);
        RAM_WEN    = push;
        RAM_WADDR  = wptr_q[AW-1:0];
        RAM_WDATA  = push ? S_DATA : '0;
        RAM_WSTRB  = '1;
        RAM_REN    = ren;
        RAM_RADDR  = rptr_q[AW-1:0];
        COUNT      = count_q;
        EMPTY      = count_q == '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    sdpram_stream_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .load_data(RAM_RDATA),
        .m_ready  (M_READY),
        .m_valid  (M_VALID),
        .m_data   (M_DATA),
        .buf_occ  (buf_occ)
    );

endmodule

// File: tb/tb_sdpram_stream_fifo.sv
// tb_sdpram_stream_fifo: directed bench with a queue-based reference model and a behavioural RAM.
module tb_sdpram_stream_fifo;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int CW = 6;

    logic          CLK = 1'b0, RST = 1'b1;
    logic          S_VALID = 1'b0, S_READY, M_VALID, M_READY = 1'b0;
    logic [W-1:0]  S_DATA = '0, M_DATA, RAM_WDATA, RAM_RDATA;
    logic          RAM_WEN, RAM_REN, RAM_RVALID, FULL, EMPTY;
    logic [AW-1:0] RAM_WADDR, RAM_RADDR;
    logic [W/8-1:0] RAM_WSTRB;
    logic [CW-1:0] COUNT;

    always #5 CLK = ~CLK;

    sdpram_stream_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .RAM_WEN(RAM_WEN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_WSTRB(RAM_WSTRB),
        .RAM_REN(RAM_REN), .RAM_RADDR(RAM_RADDR), .RAM_RVALID(RAM_RVALID), .RAM_RDATA(RAM_RDATA),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
    );

    // Behavioural RAM with one-cycle read latency, plus an injectable stray return pulse.
    logic [W-1:0] mem [D];
    logic         ram_rv = 1'b0, inj = 1'b0;
    logic [W-1:0] ram_rd = '0;
    assign RAM_RVALID = ram_rv | inj;
    assign RAM_RDATA  = inj ? 32'h0000DEAD : ram_rd;
    always @(posedge CLK) begin
        if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
        ram_rv <= RAM_REN;
        ram_rd <= mem[RAM_RADDR];
    end

    int checks = 0, fails = 0, cyc = 0, maxcnt = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endfunction

    // Reference model: words held, RAM-resident words, buffered words, addresses.
    logic [W-1:0] q[$];
    logic [W-1:0] popped[$];
    int           pop_cyc[$], acc_cyc[$];
    int           res = 0, occ = 0, wcnt = 0, rcnt = 0;
    logic         iss = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            res = 0; occ = 0; wcnt = 0; rcnt = 0; iss = 1'b0;
        end else begin : mon
            logic push, pop, load, exp_ren;
            push    = S_VALID && S_READY;
            pop     = M_VALID && M_READY;
            load    = RAM_RVALID && iss;
            exp_ren = res > 0 && (occ + int'(iss) - int'(pop) < 2);
            chk("count", COUNT, q.size());
            chk("empty", EMPTY, q.size() == 0);
            chk("full", FULL, res == D);
            chk("s_ready", S_READY, res != D);
            chk("m_valid", M_VALID, occ != 0);
            chk("wstrb", RAM_WSTRB, 4'hF);
            chk("wen", RAM_WEN, push);
            chk("ren", RAM_REN, exp_ren);
            if (push) begin
                chk("waddr", RAM_WADDR, wcnt % D);
                chk("wdata", RAM_WDATA, S_DATA);
            end
            if (RAM_REN) chk("raddr", RAM_RADDR, rcnt % D);
            if (M_VALID && q.size() > 0) chk("m_data", M_DATA, q[0]);
            if (M_VALID && q.size() == 0) chk("m_valid_no_word", 1, 0);
            if (load) chk("load_in_two", occ == 2, 0);
            if (int'(COUNT) > maxcnt) maxcnt = int'(COUNT);
            if (push) begin
                q.push_back(S_DATA);
                acc_cyc.push_back(cyc);
                wcnt++; res++;
            end
            if (RAM_REN) begin
                res--; rcnt++;
            end
            if (pop) begin
                popped.push_back(M_DATA);
                pop_cyc.push_back(cyc);
                if (q.size() > 0) void'(q.pop_front());
            end
            occ = occ + int'(load) - int'(pop);
            iss = RAM_REN;
        end
    end

    task automatic clear_logs();
        popped.delete(); pop_cyc.delete(); acc_cyc.delete();
        maxcnt = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_n(input int n, input logic [W-1:0] base);
        int k = 0, g = 0;
        S_VALID = 1'b1;
        while (k < n && g < 4000) begin
            S_DATA = base + W'(k);
            @(negedge CLK);
            if (S_READY) k++;
            @(posedge CLK); #1;
            g++;
        end
        S_VALID = 1'b0;
        if (k < n) chk("send_timeout", k, n);
    endtask

    task automatic chk_reset();
        chk("rst_s_ready", S_READY, 1);
        chk("rst_m_valid", M_VALID, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_wen", RAM_WEN, 0);
        chk("rst_ren", RAM_REN, 0);
        chk("rst_waddr", RAM_WADDR, 0);
        chk("rst_raddr", RAM_RADDR, 0);
        chk("rst_m_data", M_DATA, 0);
        chk("rst_wdata", RAM_WDATA, 0);
        chk("rst_wstrb", RAM_WSTRB, 4'hF);
    endtask

    task automatic chk_order(input string n, input int cnt, input logic [W-1:0] base);
        int bad = 0;
        chk({n, "_n"}, popped.size(), cnt);
        foreach (popped[i]) if (popped[i] !== base + W'(i)) bad++;
        chk({n, "_order_errs"}, bad, 0);
    endtask

    initial begin
        logic [W-1:0] exp1 [4];
        logic         sdone;
        exp1 = '{32'h11, 32'h12, 32'h13, 32'h14};
        tick(2);
        chk_reset();
        @(posedge CLK); #3 RST = 1'b0;
        tick(2);

        // First-word latency and back-to-back output.
        clear_logs();
        M_READY = 1'b1;
        send_n(4, 32'h11);
        tick(8);
        chk("p1_n", popped.size(), 4);
        if (popped.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("p1_data", popped[k], exp1[k]);
                chk("p1_consecutive", pop_cyc[k] - pop_cyc[0], k);
            end
            chk("first_latency", pop_cyc[0] - acc_cyc[0], 3);
        end

        // Fill to capacity with the output stalled.
        clear_logs();
        M_READY = 1'b0;
        send_n(D + 2, 32'h100);
        tick(2);
        chk("fill_count", COUNT, D + 2);
        chk("fill_full", FULL, 1);
        S_VALID = 1'b1; S_DATA = 32'hBAD;
        tick(4);
        S_VALID = 1'b0;
        chk("overfill_count", COUNT, D + 2);
        M_READY = 1'b1;
        tick(D + 10);
        chk_order("drain", D + 2, 32'h100);
        chk("drain_empty", EMPTY, 1);

        // Continuous stream across several pointer wraps.
        clear_logs();
        send_n(3 * D, 32'h1000);
        tick(10);
        chk_order("stream", 3 * D, 32'h1000);
        if (pop_cyc.size() == 3 * D) chk("stream_gapless", pop_cyc[3 * D - 1] - pop_cyc[0], 3 * D - 1);
        chk("stream_max_count_le3", maxcnt <= 3, 1);

        // Random downstream back-pressure.
        clear_logs();
        sdone = 1'b0;
        fork
            begin
                send_n(64, 32'h2000);
                sdone = 1'b1;
            end
            begin
                while (!sdone) begin
                    M_READY = 1'($urandom_range(0, 1));
                    @(posedge CLK); #1;
                end
            end
        join
        M_READY = 1'b1;
        tick(D + 10);
        chk_order("random", 64, 32'h2000);

        // Asynchronous reset with the buffer full, then a stray return pulse.
        M_READY = 1'b0;
        send_n(6, 32'h3000);
        tick(3);
        chk("pre_reset_count", COUNT, 6);
        chk("pre_reset_m_valid", M_VALID, 1);
        @(posedge CLK); #3 RST = 1'b1;
        #1 chk_reset();
        @(posedge CLK); #3 RST = 1'b0;
        @(posedge CLK); #1 inj = 1'b1;
        @(posedge CLK); #1 inj = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("stale_m_valid", M_VALID, 0);
        end
        chk("stale_count", COUNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
